uart_echo_ctrl: RTL
===================

Name: uart_echo_ctrl

Overview:
Scheduler between the UART receiver and the single UART transmitter in the echo design. It buffers received bytes in a small FIFO and sequences them onto the TX valid/ready handshake. It optionally inserts LF (0x0A) after every CR (0x0D). It flags overflow and reports occupancy for debug and status.

Parameters:
DEPTH, 8, FIFO depth in bytes; must be a power of 2 and at least 2.
ADD_LF, 1, when 1, transmit 0x0A immediately after every transmitted 0x0D.
AW, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
rx_data  in  8  received byte.
enable  in  1  when 0, no new byte is popped; any byte in flight completes.
clr_ovf  in  1  one-cycle strobe; clears overflow.
tx_ready  in  1  transmitter can accept a byte this cycle.
tx_valid  out  1  tx_data is valid; held until accepted.
tx_data  out  8  byte to transmit.
overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.
fifo_count  out  AW+1  number of bytes currently in the FIFO, 0..DEPTH.
busy  out  1  high when the FSM is not in IDLE or fifo_count != 0.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, pointers 0, state IDLE.
- Output reset values: tx_valid=0, tx_data=8'h00, overflow=0, fifo_count=0, busy=0.
- FIFO:
  - push when rx_valid && (count<DEPTH || pop same cycle).
  - pop is requested only by the FSM.
  - push and pop in the same cycle: count unchanged, both pointers advance.
  - pointers wrap modulo DEPTH.
- Overflow:
  - rx_valid with count==DEPTH and no pop that cycle: byte dropped, overflow<=1.
  - clr_ovf clears overflow. If a drop occurs in the same cycle as clr_ovf, set wins.
- Handshake: a transfer happens in a cycle with tx_valid && tx_ready. tx_data is stable while tx_valid=1 and not yet accepted.
- FSM states: IDLE, SEND, SEND_LF.
  - IDLE: tx_valid=0. If enable && count!=0: pop, tx_data<=head, go to SEND.
  - SEND: tx_valid=1. On transfer:
    - if ADD_LF && tx_data==8'h0D: tx_data<=8'h0A, go to SEND_LF;
    - else if enable && count!=0: pop, tx_data<=head, stay in SEND (back-to-back, no bubble);
    - else go to IDLE.
  - SEND_LF: tx_valid=1, tx_data=8'h0A. On transfer: same pop/IDLE decision as SEND.
  - No transfer in SEND or SEND_LF: hold state and data.
- Latency: byte written into an empty FIFO in cycle N while in IDLE gives tx_valid=1 in cycle N+2.
- Throughput: with tx_ready held at 1, one byte per cycle (plus one LF cycle per CR).
- Deasserting enable does not drop the current byte or the pending LF; the FSM finishes them, then returns to IDLE.
- Reset mid-transfer: byte is discarded, tx_valid drops immediately (asynchronous), FIFO is cleared.
- fifo_count is registered; it reflects pushes and pops of the previous edge.

Decomposition:
- Package uart_echo_pkg:
  - CR_CODE=8'h0D, LF_CODE=8'h0A;
  - state enum typedef (IDLE/SEND/SEND_LF);
  - byte_t typedef (8-bit).
- Sub-module sync_fifo (parameters DEPTH and width 8; push/pop/full/empty/count). It is reusable by the TX path later.
- The FSM, handshake logic and overflow flag live in uart_echo_ctrl.

Test Plan:
- Single byte: rx 0x41 at cycle N, tx_ready=1 -> tx_valid rises at N+2 with tx_data=0x41, one transfer, then IDLE with busy=0.
- CR expansion (ADD_LF=1): rx 0x0D -> two transfers, 0x0D then 0x0A, on consecutive cycles. With ADD_LF=0: only 0x0D.
- Backpressure: rx 0x31,0x32,0x33 with tx_ready=0 for 20 cycles -> tx_data holds 0x31 and fifo_count=2. Release -> 0x31,0x32,0x33 on three consecutive cycles.
- Overflow: tx_ready=0 and 10 strobes 0x00..0x09 with DEPTH=8 -> first byte in SEND, fifo_count=8, 0x09 dropped, overflow=1. clr_ovf -> overflow=0. Drain order is 0x00..0x08.
- Enable gating: enable=0 with 3 bytes queued -> tx_valid stays 0. Drop enable during a CR transfer -> the LF still goes out, then IDLE.
- Async reset mid-SEND: rst=0 between clock edges -> tx_valid=0, fifo_count=0 and overflow=0 immediately. After release, a new byte 0x55 echoes normally.

Source files
------------

// File: rtl/uart_echo_pkg.sv
// Shared types and character codes for the UART echo path.
package uart_echo_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t CR_CODE = 8'h0D;
  localparam byte_t LF_CODE = 8'h0A;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    SEND_LF = 2'd2
  } state_t;

endpackage

// File: rtl/uart_echo_ctrl_sync_fifo.sv
// Synchronous byte FIFO with show-ahead read data; reusable by the TX path.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_ctrl.sv
// Buffers received bytes and sequences them onto the TX valid/ready handshake,
// optionally following every CR with an LF.
module uart_echo_ctrl
  import uart_echo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADD_LF = 1,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        enable,
  input  logic        clr_ovf,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        overflow,
  output logic [AW:0] fifo_count,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a byte moves in any cycle where tx_valid && tx_ready; while
  // tx_valid is high and not yet accepted, tx_data and the state are frozen.

  state_t state;
  byte_t  head;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  logic   xfer;
  logic   lf_next;
  logic   can_pop;
  logic   drop;

  assign xfer    = tx_valid && tx_ready;
  assign can_pop = enable && !empty;
  assign lf_next = (ADD_LF != 0) && (tx_data == CR_CODE);

  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = can_pop;
      SEND:    pop = xfer && !lf_next && can_pop;
      SEND_LF: pop = xfer && can_pop;
      default: pop = 1'b0;
    endcase
  end

  assign push = rx_valid && (!full || pop);
  assign drop = rx_valid && full && !pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (rx_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= head;
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND, SEND_LF: begin
          if (xfer) begin
            if (state == SEND && lf_next) begin
              tx_data <= LF_CODE;
              state   <= SEND_LF;
            end else if (pop) begin
              tx_data <= head;
              state   <= SEND;
            end else begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign dbg_state = state;

endmodule
